// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit serializer slice.
package serializer_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry word buffer: holds the next word while the current one shifts out.
module bit_serializer_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Capture on push, release on pop; a push always wins so the entry is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (push) data <= wdata;
      full <= push | (full & ~pop);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage, MSB first, gap-free across back-to-back words.
// Optional: define BIT_SERIALIZER_PARITY_EN to append an even-parity bit
// after the LSB of every frame.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL);

  state_t          state, state_n;
  logic [FL-1:0]   sreg;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] hold_data, ld_word;
  logic            hold_full;
  logic            xfer, last, push, pop, ld;

  // Frame image as loaded into the shifter: data, optionally followed by parity.
  function automatic logic [FL-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef BIT_SERIALIZER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  assign load_ready = ~hold_full;
  assign xfer       = load_valid & ~hold_full;
  assign last       = (cnt == CW'(FL - 1));

  bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .data  (hold_data),
    .full  (hold_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and shifter/hold control. At the last-bit edge the held word
  // takes priority; otherwise a word arriving on that edge loads directly.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    pop     = 1'b0;
    ld      = 1'b0;
    ld_word = data_in;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          ld      = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!last) begin
          push = xfer;
        end else if (hold_full) begin
          pop     = 1'b1;
          ld      = 1'b1;
          ld_word = hold_data;
        end else if (xfer) begin
          ld = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Shifter, bit counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg        <= '0;
      cnt         <= '0;
      serial_out  <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (ld) begin
        sreg        <= frame_of(ld_word);
        cnt         <= '0;
        serial_out  <= ld_word[WIDTH-1];
        bit_valid   <= 1'b1;
        frame_start <= 1'b1;
      end else if (state == S_SHIFT && state_n == S_SHIFT) begin
        sreg        <= sreg << 1;
        cnt         <= cnt + CW'(1);
        serial_out  <= sreg[FL-2];
        bit_valid   <= 1'b1;
        frame_start <= 1'b0;
      end else begin
        sreg        <= '0;
        cnt         <= '0;
        serial_out  <= IDLE_BIT;
        bit_valid   <= 1'b0;
        frame_start <= 1'b0;
      end
      busy <= (state_n == S_SHIFT) | push | (hold_full & ~pop);
    end
  end

endmodule
